// File: rtl/irq_sequencer.sv
// Interrupt sequencer: latches rising edges on four request lines, arbitrates
// round-robin, and steers the CPU PC/zero flag into and out of handlers.
module irq_sequencer #(
  parameter int                  PC_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0] VEC_BASE = 10'h3C0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          irq,
  input  logic                mask_we,
  input  logic [3:0]          mask_in,
  input  logic [5:0]          opcode,
  input  logic [PC_WIDTH-1:0] pc_in,
  input  logic                zero_in,
  output logic                s_int,
  output logic [PC_WIDTH-1:0] vec_addr,
  output logic                s_ret,
  output logic [PC_WIDTH-1:0] ret_addr,
  output logic                z_saved,
  output logic [3:0]          ack,
  output logic                busy
);

  localparam logic [5:0] RETI = 6'b111111;

  typedef enum logic [1:0] {IDLE, DISPATCH, SERVICE} state_t;

  state_t              state;
  logic [3:0]          irq_q;
  logic [3:0]          pending;
  logic [3:0]          mask;
  logic [1:0]          rr_ptr;
  logic [1:0]          id;
  logic [PC_WIDTH-1:0] saved_pc;
  logic                z_q;

  logic [3:0] rise;
  logic [3:0] eligible;
  logic [3:0] grant_clr;
  logic [1:0] win_id;
  logic       win_valid;
  logic [1:0] idx;

  assign rise      = irq & ~irq_q;
  assign eligible  = pending & mask;
  assign grant_clr = (state == DISPATCH) ? (4'b0001 << id) : 4'b0000;

  // Walk from farthest to nearest so the source right after rr_ptr wins last.
  always_comb begin
    win_id    = rr_ptr;
    win_valid = 1'b0;
    idx       = 2'b00;
    for (int k = 4; k >= 1; k--) begin
      idx = rr_ptr + 2'(k);
      if (eligible[idx]) begin
        win_id    = idx;
        win_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      irq_q    <= 4'b0000;
      pending  <= 4'b0000;
      mask     <= 4'b0000;
      rr_ptr   <= 2'b00;
      id       <= 2'b00;
      saved_pc <= '0;
      z_q      <= 1'b0;
    end else begin
      irq_q <= irq;
      if (mask_we)
        mask <= mask_in;
      // A new edge on the line being granted keeps it pending.
      pending <= (pending & ~grant_clr) | rise;
      case (state)
        IDLE: begin
          if (win_valid) begin
            id     <= win_id;
            rr_ptr <= win_id;
            state  <= DISPATCH;
          end
        end
        DISPATCH: begin
          saved_pc <= pc_in;
          z_q      <= zero_in;
          state    <= SERVICE;
        end
        SERVICE: begin
          if (opcode == RETI)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_int    = (state == DISPATCH);
  assign vec_addr = s_int ? (VEC_BASE + PC_WIDTH'({id, 2'b00})) : '0;
  assign ack      = s_int ? (4'b0001 << id) : 4'b0000;
  assign busy     = (state == SERVICE);
  assign s_ret    = busy && (opcode == RETI);
  assign ret_addr = saved_pc;
  assign z_saved  = z_q;

endmodule

// File: doc/irq_sequencer.md
# irq_sequencer

Interrupt sequencer for the single-cycle CPU. It latches edge-triggered requests from up to four I/O sources and arbitrates between them round-robin. At an instruction boundary it forces the PC to a per-source vector and saves the return PC and zero flag. On the RETI opcode (111111) it restores both. It sits beside the control unit and drives extra select lines into the PC mux and the zero-flag register.

## Interface
- PC_WIDTH, 10, width of PC and addresses
- VEC_BASE, 10'h3C0, vector of source 0; source i vectors to VEC_BASE + 4*i
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- irq  in  4  request lines, rising-edge sensitive
- mask_we  in  1  write strobe for the mask register
- mask_in  in  4  new mask value (1 = enabled)
- opcode  in  6  opcode of the instruction currently fetched
- pc_in  in  PC_WIDTH  address of the instruction currently fetched
- zero_in  in  1  current zero flag
- s_int  out  1  PC mux selects vec_addr; CPU must suppress we3/wez this cycle
- vec_addr  out  PC_WIDTH  vector target, valid while s_int=1
- s_ret  out  1  PC mux selects ret_addr and the zero register loads z_saved
- ret_addr  out  PC_WIDTH  saved return PC
- z_saved  out  1  saved zero flag
- ack  out  4  one-hot grant pulse, high during the dispatch cycle
- busy  out  1  handler in progress (SERVICE state)

## Operation
- Edge detect: irq_q holds irq from the previous cycle.
  - pending[i] is set at any edge where irq[i]=1 and irq_q[i]=0.
  - pending[i] is cleared at the DISPATCH edge that grants i.
  - A simultaneous set and clear on the same line leaves pending set.
- Mask: the mask register loads mask_in on mask_we in any state. A masked pending bit stays pending and becomes eligible once unmasked.
- Eligible set: pending & mask.
- Arbitration is round-robin. Search starts at rr_ptr+1 mod 4; after a grant, rr_ptr is set to the granted id.
- State machine has three states:
  - IDLE: if the eligible set is non-zero, latch the winning id and go to DISPATCH. RETI in IDLE is ignored: s_ret stays 0 and the state stays IDLE.
  - DISPATCH (exactly one cycle):
    - Outputs: s_int=1, vec_addr = VEC_BASE + {id,2'b00} with truncation to PC_WIDTH, ack[id]=1.
    - At the closing edge: saved_pc <= pc_in, z_saved <= zero_in, pending[id] cleared, next state SERVICE.
    - The instruction at pc_in is not executed and is re-fetched after return.
  - SERVICE: busy=1. No nesting; new edges only set pending. When opcode==6'b111111, assert s_ret=1 for that cycle and return to IDLE at the next edge. Any other opcode stays in SERVICE.
- ret_addr and z_saved are held until the next DISPATCH.

## Timing
- Reset values:
  - state IDLE; pending, irq_q and rr_ptr 0.
  - mask 0, so all sources are disabled.
  - saved_pc 0, z_saved 0.
  - s_int, s_ret, ack, busy all 0.
- Latency: a rising irq sampled at edge N sets pending at edge N. If the block is IDLE and the source is unmasked, the next state is DISPATCH from edge N+1, and s_int is high in cycle N+1..N+2.
- Outputs are decoded combinationally from state and registered id. s_ret is combinational on opcode within SERVICE.
- Return: RETI seen in cycle M makes s_ret high in cycle M. The CPU loads the PC at edge M+1 and the block is IDLE after edge M+1. A pending eligible request may dispatch from edge M+2 at the earliest. There are never back-to-back DISPATCH cycles.
- Reset asserted mid-DISPATCH or mid-SERVICE returns every output to its reset value immediately. Saved context is lost.
- A request held high continuously produces exactly one pending event.

## Test plan
- Reset, mask_in=4'b1111, irq[2] pulses at edge N with pc_in=10'h025 and zero_in=1 → s_int=1 and ack=4'b0100 in cycle N+1..N+2, vec_addr=10'h3C8, busy=1 afterwards, ret_addr=10'h025, z_saved=1.
- In SERVICE, opcode=6'b111111 → s_ret=1 the same cycle and busy=0 after the next edge. Any other opcode keeps busy=1.
- irq[0] and irq[3] rise on the same edge with rr_ptr=0 → irq[3] is granted first (vec 10'h3CC). After RETI, irq[0] is granted (vec 10'h3C0).
- irq[1] with mask=4'b0000 → no s_int. Pending persists; after mask_we with 4'b0010, dispatch occurs 1 cycle later with vec 10'h3C4.
- irq[1] rises during SERVICE → no nested dispatch; it dispatches 2 cycles after the RETI cycle. RETI issued in IDLE → s_ret stays 0.
- Reset pulsed in the middle of SERVICE → busy, s_int, s_ret, ack and ret_addr all 0, and pending cleared.
